// File: rtl/seg_scan_if.sv
// Seven-segment monitor bus: the display side drives anode/segment lines and
// the error clear, the monitor returns decoded digits and status.
`timescale 1ns/1ps
interface seg_scan_if;
  logic [3:0] an;
  logic [6:0] seg;
  logic       clr_err;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dvalid;
  logic       frame;
  logic       err_seg;
  logic       err_an;

  modport master (
    output an, seg, clr_err,
    input  digit0, digit1, digit2, digit3, dvalid, frame, err_seg, err_an
  );

  modport slave (
    input  an, seg, clr_err,
    output digit0, digit1, digit2, digit3, dvalid, frame, err_seg, err_an
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Passive seven-segment scan monitor: waits for each anode/segment dwell to
// settle, decodes the pattern and keeps one code register per digit position.
`timescale 1ns/1ps
module seg_scan_capture #(
  parameter int unsigned SETTLE     = 4,
  parameter logic [3:0]  FRAME_MASK = 4'b1111
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);
  localparam logic [CW-1:0] CAP_AT  = CW'(SETTLE - 1);

  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    digit_q [4];
  logic [3:0]    digit_d [4];
  logic [3:0]    dvalid_q, dvalid_d;
  logic [3:0]    seen_q, seen_d;
  logic          frame_q, frame_d;
  logic          err_seg_q, err_seg_d;
  logic          err_an_q, err_an_d;

  logic       same;
  logic       capture;
  logic [3:0] sel;
  logic       one_sel;
  logic       multi_sel;
  logic [3:0] code;
  logic       bad_code;
  logic [3:0] seen_next;
  logic       set_seg;
  logic       set_an;

  always_comb begin
    code     = 4'hE;
    bad_code = 1'b0;
    case (seg_q)
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b1111111: code = 4'hF;
      default:    bad_code = 1'b1;
    endcase
  end

  always_comb begin
    an_d      = bus.an;
    seg_d     = bus.seg;
    same      = ({bus.an, bus.seg} == {an_q, seg_q});
    cnt_d     = cnt_q;
    if (!same)
      cnt_d = '0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + CW'(1);
    // Fires on the single edge where the counter crosses SETTLE-1; once
    // saturated the dwell can never capture again.
    capture   = same && (cnt_q == CAP_AT);

    sel       = ~an_q;
    one_sel   = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
    multi_sel = (sel != 4'b0000) && !one_sel;

    digit_d   = digit_q;
    dvalid_d  = dvalid_q;
    seen_next = seen_q;
    set_seg   = 1'b0;
    set_an    = capture && multi_sel;
    frame_d   = 1'b0;

    if (capture && one_sel) begin
      for (int i = 0; i < 4; i++)
        if (sel[i]) digit_d[i] = code;
      dvalid_d  = dvalid_q | sel;
      seen_next = seen_q | sel;
      set_seg   = bad_code;
    end

    seen_d = seen_next;
    if (capture && one_sel && ((seen_next & FRAME_MASK) == FRAME_MASK)) begin
      frame_d = 1'b1;
      seen_d  = 4'b0000;
    end

    // A new error at the clearing edge survives the clear.
    err_seg_d = (err_seg_q & ~bus.clr_err) | set_seg;
    err_an_d  = (err_an_q & ~bus.clr_err) | set_an;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      cnt_q     <= '0;
      digit_q   <= '{default: 4'h0};
      dvalid_q  <= 4'b0000;
      seen_q    <= 4'b0000;
      frame_q   <= 1'b0;
      err_seg_q <= 1'b0;
      err_an_q  <= 1'b0;
    end else begin
      an_q      <= an_d;
      seg_q     <= seg_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      dvalid_q  <= dvalid_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      err_seg_q <= err_seg_d;
      err_an_q  <= err_an_d;
    end
  end

  assign bus.digit0  = digit_q[0];
  assign bus.digit1  = digit_q[1];
  assign bus.digit2  = digit_q[2];
  assign bus.digit3  = digit_q[3];
  assign bus.dvalid  = dvalid_q;
  assign bus.frame   = frame_q;
  assign bus.err_seg = err_seg_q;
  assign bus.err_an  = err_an_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: two instances (full frame mask and mask 0011)
// driven from the same bus stimulus and checked against a dwell-level model.
`timescale 1ns/1ps
module tb_seg_scan_capture;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seg_scan_if bus ();
  seg_scan_if bus2 ();

  seg_scan_capture #(.SETTLE(SETTLE), .FRAME_MASK(4'b1111)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  seg_scan_capture #(.SETTLE(SETTLE), .FRAME_MASK(4'b0011)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  always #5 clk = ~clk;

  logic [3:0] obs_digit [4];
  assign obs_digit[0] = bus.digit0;
  assign obs_digit[1] = bus.digit1;
  assign obs_digit[2] = bus.digit2;
  assign obs_digit[3] = bus.digit3;

  // Reference model: a dwell is captured once it has been seen on
  // SETTLE+1 consecutive edges; captures are interpreted by digit position.
  logic [6:0]  seg_tbl [10];
  logic [10:0] m_last;
  int          m_run;
  logic [3:0]  m_digit [4];
  logic [3:0]  m_dvalid;
  logic        m_err_seg, m_err_an;
  logic [3:0]  m_seen1, m_seen2;
  logic        m_frame1, m_frame2;
  int          obs_f1, obs_f2, exp_f1, exp_f2, frame_mis;

  function automatic logic [4:0] model_decode(input logic [6:0] s);
    for (int k = 0; k < 10; k++)
      if (s == seg_tbl[k]) return {1'b0, 4'(k)};
    if (s == 7'h7F) return {1'b0, 4'hF};
    return {1'b1, 4'hE};
  endfunction

  task automatic model_reset();
    m_last   = {4'hF, 7'h7F};
    m_run    = 1;
    for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
    m_dvalid = 4'b0000;
    m_err_seg = 1'b0;
    m_err_an  = 1'b0;
    m_seen1  = 4'b0000;
    m_seen2  = 4'b0000;
    m_frame1 = 1'b0;
    m_frame2 = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] an, input logic [6:0] seg, input logic clr);
    logic       cap;
    logic       set_seg, set_an;
    logic [4:0] dec;
    int         nz, pos;
    cap = 1'b0; set_seg = 1'b0; set_an = 1'b0;
    m_frame1 = 1'b0; m_frame2 = 1'b0;
    if ({an, seg} != m_last) begin
      m_last = {an, seg};
      m_run  = 1;
    end else if (m_run <= SETTLE) begin
      m_run++;
      cap = (m_run == SETTLE + 1);
    end
    if (cap) begin
      nz = 0; pos = 0;
      for (int i = 0; i < 4; i++)
        if (!an[i]) begin nz++; pos = i; end
      if (nz == 1) begin
        dec = model_decode(seg);
        m_digit[pos]  = dec[3:0];
        m_dvalid[pos] = 1'b1;
        set_seg       = dec[4];
        m_seen1[pos]  = 1'b1;
        m_seen2[pos]  = 1'b1;
        if (m_seen1 == 4'b1111) begin m_frame1 = 1'b1; m_seen1 = 4'b0000; end
        if ((m_seen2 & 4'b0011) == 4'b0011) begin m_frame2 = 1'b1; m_seen2 = 4'b0000; end
      end else if (nz >= 2) begin
        set_an = 1'b1;
      end
    end
    if (clr) begin m_err_seg = 1'b0; m_err_an = 1'b0; end
    m_err_seg = m_err_seg | set_seg;
    m_err_an  = m_err_an | set_an;
  endtask

  // One clock: present inputs, take the edge, record frame activity at negedge.
  task automatic step(input logic [3:0] an, input logic [6:0] seg, input logic clr);
    bus.an = an;   bus.seg = seg;   bus.clr_err = clr;
    bus2.an = an;  bus2.seg = seg;  bus2.clr_err = clr;
    @(posedge clk);
    model_edge(an, seg, clr);
    @(negedge clk);
    obs_f1 += int'(bus.frame);
    obs_f2 += int'(bus2.frame);
    exp_f1 += int'(m_frame1);
    exp_f2 += int'(m_frame2);
    if (bus.frame !== m_frame1 || bus2.frame !== m_frame2) frame_mis++;
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
    repeat (n) step(an, seg, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.an = 4'hF;  bus.seg = 7'h7F;  bus.clr_err = 1'b0;
    bus2.an = 4'hF; bus2.seg = 7'h7F; bus2.clr_err = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_digit[i] !== 4'h0) begin errors++; $display("FAIL reset_digit%0d got %h want 0", i, obs_digit[i]); end
    end
    checks++;
    if ({bus.dvalid, bus.frame, bus.err_seg, bus.err_an} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got dvalid=%b frame=%b err_seg=%b err_an=%b want all 0",
               bus.dvalid, bus.frame, bus.err_seg, bus.err_an);
    end
    @(negedge clk);
    rst = 1'b0;
    dwell(4'hF, 7'h7F, 50);
    checks++;
    if (bus.dvalid !== 4'b0000 || obs_f1 !== 0) begin
      errors++; $display("FAIL idle_bus got dvalid=%b frames=%0d want 0000/0", bus.dvalid, obs_f1);
    end
  endtask

  task automatic test_single_digit();
    dwell(4'b1110, 7'b0100100, SETTLE);
    checks++;
    if (bus.dvalid !== 4'b0000) begin errors++; $display("FAIL single_early got dvalid=%b want 0000", bus.dvalid); end
    step(4'b1110, 7'b0100100, 1'b0);
    checks++;
    if (bus.digit0 !== 4'h2 || bus.dvalid !== 4'b0001) begin
      errors++; $display("FAIL single_capture got digit0=%h dvalid=%b want 2/0001", bus.digit0, bus.dvalid);
    end
    dwell(4'b1110, 7'b0100100, 5);
    dwell(4'hF, 7'h7F, 3);
    checks++;
    if (bus.digit0 !== m_digit[0] || bus.dvalid !== m_dvalid) begin
      errors++; $display("FAIL single_hold got digit0=%h dvalid=%b want %h/%b", bus.digit0, bus.dvalid, m_digit[0], m_dvalid);
    end
  endtask

  task automatic test_glitch();
    dwell(4'b1101, 7'b1111001, 3);
    dwell(4'hF, 7'h7F, 3);
    checks++;
    if (bus.dvalid[1] !== 1'b0 || bus.digit1 !== 4'h0) begin
      errors++; $display("FAIL glitch got dvalid1=%b digit1=%h want 0/0", bus.dvalid[1], bus.digit1);
    end
    dwell(4'b1101, 7'b1111001, 6);
    dwell(4'hF, 7'h7F, 2);
    checks++;
    if (bus.digit1 !== 4'h1 || bus.dvalid[1] !== 1'b1) begin
      errors++; $display("FAIL glitch_long got digit1=%h dvalid1=%b want 1/1", bus.digit1, bus.dvalid[1]);
    end
  endtask

  task automatic test_full_scan();
    for (int s = 0; s < 2; s++) begin
      obs_f1 = 0; obs_f2 = 0; exp_f1 = 0; exp_f2 = 0; frame_mis = 0;
      dwell(4'b1110, 7'b1111000, 6);
      dwell(4'b1101, 7'b0010000, 6);
      dwell(4'b1011, 7'b1111111, 6);
      dwell(4'b0111, 7'b1000000, 6);
      dwell(4'hF, 7'h7F, 2);
      checks++;
      if ({obs_digit[0], obs_digit[1], obs_digit[2], obs_digit[3]} !== 16'h79F0) begin
        errors++; $display("FAIL scan%0d_digits got %h%h%h%h want 79F0", s,
                           obs_digit[0], obs_digit[1], obs_digit[2], obs_digit[3]);
      end
      checks++;
      if (obs_f1 !== 1 || obs_f2 !== 1 || frame_mis !== 0) begin
        errors++; $display("FAIL scan%0d_frame got pulses=%0d/%0d misplaced=%0d want 1/1/0", s, obs_f1, obs_f2, frame_mis);
      end
    end
  endtask

  task automatic test_errors();
    dwell(4'b1110, 7'b0101010, 6);
    checks++;
    if (bus.digit0 !== 4'hE || bus.err_seg !== 1'b1) begin
      errors++; $display("FAIL err_seg got digit0=%h err_seg=%b want E/1", bus.digit0, bus.err_seg);
    end
    dwell(4'b1100, 7'b0011001, 6);
    checks++;
    if (bus.err_an !== 1'b1 || bus.digit0 !== 4'hE || bus.digit1 !== 4'h9) begin
      errors++; $display("FAIL err_an got err_an=%b digit0=%h digit1=%h want 1/E/9", bus.err_an, bus.digit0, bus.digit1);
    end
    step(4'hF, 7'h7F, 1'b1);
    checks++;
    if (bus.err_seg !== 1'b0 || bus.err_an !== 1'b0) begin
      errors++; $display("FAIL clr_err got err_seg=%b err_an=%b want 0/0", bus.err_seg, bus.err_an);
    end
    dwell(4'b1011, 7'b0111111, SETTLE);
    step(4'b1011, 7'b0111111, 1'b1);
    step(4'hF, 7'h7F, 1'b0);
    checks++;
    if (bus.err_seg !== 1'b1 || bus.err_an !== 1'b0 || bus.digit2 !== 4'hE) begin
      errors++; $display("FAIL clr_vs_set got err_seg=%b err_an=%b digit2=%h want 1/0/E", bus.err_seg, bus.err_an, bus.digit2);
    end
  endtask

  task automatic test_random();
    logic [3:0] an;
    logic [6:0] seg;
    int         len, r;
    frame_mis = 0; obs_f1 = 0; obs_f2 = 0; exp_f1 = 0; exp_f2 = 0;
    for (int d = 0; d < 60; d++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      an = ~(4'b0001 << $urandom_range(0, 3));
      else if (r < 85) an = 4'hF;
      else             an = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      if (r < 80)      seg = seg_tbl[$urandom_range(0, 9)];
      else if (r < 90) seg = 7'h7F;
      else             seg = 7'($urandom_range(0, 127));
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) step(an, seg, ($urandom_range(0, 19) == 0));
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_digit[i] !== m_digit[i]) begin
          errors++; $display("FAIL rand%0d_digit%0d got %h want %h", d, i, obs_digit[i], m_digit[i]);
        end
      end
      checks++;
      if ({bus.dvalid, bus.err_seg, bus.err_an} !== {m_dvalid, m_err_seg, m_err_an}) begin
        errors++; $display("FAIL rand%0d_flags got dvalid=%b err_seg=%b err_an=%b want %b/%b/%b", d,
                           bus.dvalid, bus.err_seg, bus.err_an, m_dvalid, m_err_seg, m_err_an);
      end
    end
    checks++;
    if (frame_mis !== 0 || obs_f1 !== exp_f1 || obs_f2 !== exp_f2) begin
      errors++; $display("FAIL rand_frame got misplaced=%0d pulses=%0d/%0d want 0 and %0d/%0d",
                         frame_mis, obs_f1, obs_f2, exp_f1, exp_f2);
    end
  endtask

  task automatic test_reset_mid();
    dwell(4'b1011, 7'b0110000, 2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({obs_digit[0], obs_digit[1], obs_digit[2], obs_digit[3], bus.dvalid,
         bus.frame, bus.err_seg, bus.err_an} !== 23'b0) begin
      errors++; $display("FAIL reset_mid got digits=%h%h%h%h dvalid=%b errs=%b%b want all 0",
                         obs_digit[0], obs_digit[1], obs_digit[2], obs_digit[3], bus.dvalid, bus.err_seg, bus.err_an);
    end
    @(negedge clk);
    rst = 1'b0;
    dwell(4'b1011, 7'b0110000, SETTLE);
    checks++;
    if (bus.dvalid !== 4'b0000) begin errors++; $display("FAIL reset_mid_early got dvalid=%b want 0000", bus.dvalid); end
    step(4'b1011, 7'b0110000, 1'b0);
    checks++;
    if (bus.digit2 !== 4'h3 || bus.dvalid !== 4'b0100) begin
      errors++; $display("FAIL reset_mid_capture got digit2=%h dvalid=%b want 3/0100", bus.digit2, bus.dvalid);
    end
  endtask

  initial begin
    seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001; seg_tbl[2] = 7'b0100100;
    seg_tbl[3] = 7'b0110000; seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
    seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000; seg_tbl[8] = 7'b0000000;
    seg_tbl[9] = 7'b0010000;
    obs_f1 = 0; obs_f2 = 0; exp_f1 = 0; exp_f2 = 0; frame_mis = 0;
    test_reset();
    test_single_digit();
    test_glitch();
    test_full_scan();
    test_errors();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
